fpga_config_loader: RTL and testbench

Serial configuration loader for the `fpga` fabric. It accepts a word-wide configuration bitstream over a valid/ready handshake and assembles it in a shadow register. It checks an XOR checksum and only then commits the LUT SRAM, connection-box and switch-box configuration vectors to the fabric. It replaces hand-driven parallel `sramConfig`/`cbconfig`/`sconfig` registers and is parametrised for larger fabrics.

---
 rtl/fpga_config_loader.sv | 163 ++++++++++++++++
 tb/tb_fpga_config_loader.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : fpga_config_loader
// Brief    : Word-stream configuration loader with XOR checksum; commits the
//            LUT, connection-box and switch-box vectors only after a good load.
// Revision : 1.0 - initial release
// ============================================================================
module fpga_config_loader #(
    parameter int WORD_W    = 8,
    parameter int SRAM_BITS = 144,
    parameter int CB_BITS   = 420,
    parameter int SB_BITS   = 240
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WORD_W-1:0]    din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [SRAM_BITS-1:0] sramConfig,
    output logic [CB_BITS-1:0]   cbconfig,
    output logic [SB_BITS-1:0]   sconfig,
    output logic                 busy,
    output logic                 config_valid,
    output logic                 error,
    output logic                 fabric_reset
);

    localparam int TOTAL    = SRAM_BITS + CB_BITS + SB_BITS;
    localparam int NWORDS   = (TOTAL + WORD_W - 1) / WORD_W;
    localparam int PAD      = NWORDS * WORD_W - TOTAL;
    localparam int SHADOW_W = NWORDS * WORD_W;
    localparam int CNT_W    = $clog2(NWORDS + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NWORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CSUM   = 3'd2,
        S_COMMIT = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [WORD_W-1:0]     r_xor;
    logic [SHADOW_W-1:0]   r_shadow;
    logic [SRAM_BITS-1:0]  r_sram;
    logic [CB_BITS-1:0]    r_cb;
    logic [SB_BITS-1:0]    r_sb;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_valid;
    logic                  r_error;
    logic                  r_freset;

    logic                  w_xfer;
    logic [SHADOW_W-1:0]   w_shadow_next;

    assign w_xfer = din_valid && r_ready;

    // Words enter at the bottom, so word 0 ends up in the top bits.
    generate
        if (NWORDS > 1) begin : g_shift
            assign w_shadow_next = {r_shadow[SHADOW_W-WORD_W-1:0], din};
        end else begin : g_single
            assign w_shadow_next = din;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_xor    <= '0;
            r_shadow <= '0;
            r_sram   <= '0;
            r_cb     <= '0;
            r_sb     <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_error  <= 1'b0;
            r_freset <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE, S_ERROR: begin
                    if (start) begin
                        r_state  <= S_LOAD;
                        r_cnt    <= '0;
                        r_xor    <= '0;
                        r_error  <= 1'b0;
                        r_valid  <= 1'b0;
                        r_ready  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_freset <= 1'b1;
                    end
                end

                S_LOAD: begin
                    if (start) begin
                        r_cnt <= '0;
                        r_xor <= '0;
                    end else if (w_xfer) begin
                        r_shadow <= w_shadow_next;
                        r_xor    <= r_xor ^ din;
                        r_cnt    <= r_cnt + CNT_W'(1);
                        if (r_cnt == C_LAST) begin
                            r_state <= S_CSUM;
                        end
                    end
                end

                S_CSUM: begin
                    if (start) begin
                        r_state <= S_LOAD;
                        r_cnt   <= '0;
                        r_xor   <= '0;
                    end else if (w_xfer) begin
                        r_ready <= 1'b0;
                        if (din == r_xor) begin
                            r_state <= S_COMMIT;
                        end else begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                S_COMMIT: begin
                    // The only place the fabric-facing vectors ever change.
                    r_sram   <= r_shadow[SHADOW_W-1 -: SRAM_BITS];
                    r_cb     <= r_shadow[SHADOW_W-1-SRAM_BITS -: CB_BITS];
                    r_sb     <= r_shadow[PAD +: SB_BITS];
                    r_valid  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_freset <= 1'b0;
                    r_state  <= S_IDLE;
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_ready  <= 1'b0;
                    r_busy   <= 1'b0;
                    r_valid  <= 1'b0;
                    r_freset <= 1'b1;
                end
            endcase
        end
    end

    assign din_ready    = r_ready;
    assign busy         = r_busy;
    assign config_valid = r_valid;
    assign error        = r_error;
    assign fabric_reset = r_freset;
    assign sramConfig   = r_sram;
    assign cbconfig     = r_cb;
    assign sconfig      = r_sb;

endmodule
`default_nettype wire

// File: tb/tb_fpga_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpga_config_loader
// Brief    : Directed scoreboard bench for the configuration loader (8- and
//            16-bit stream widths).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpga_config_loader;

    localparam int W   = 8;
    localparam int SR  = 144;
    localparam int CBB = 420;
    localparam int SBB = 240;
    localparam int TOT = SR + CBB + SBB;
    localparam int NW  = (TOT + W - 1) / W;
    localparam int PD  = NW * W - TOT;
    localparam int W2  = 16;
    localparam int NW2 = (TOT + W2 - 1) / W2;
    localparam int PD2 = NW2 * W2 - TOT;

    typedef struct packed {
        logic [SR-1:0]  sram;
        logic [CBB-1:0] cb;
        logic [SBB-1:0] sb;
        logic           cv;
        logic           err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic           start, din_valid, din_ready, busy, config_valid, error, fabric_reset;
    logic [W-1:0]   din;
    logic [SR-1:0]  sram;
    logic [CBB-1:0] cb;
    logic [SBB-1:0] sb;

    logic           start2, din_valid2, din_ready2, busy2, cv2, err2, fr2;
    logic [W2-1:0]  din2;
    logic [SR-1:0]  sram2;
    logic [CBB-1:0] cb2;
    logic [SBB-1:0] sb2;

    fpga_config_loader dut (
        .clk(clk), .reset(reset), .start(start), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .sramConfig(sram), .cbconfig(cb), .sconfig(sb),
        .busy(busy), .config_valid(config_valid), .error(error), .fabric_reset(fabric_reset)
    );

    fpga_config_loader #(.WORD_W(W2)) u16 (
        .clk(clk), .reset(reset), .start(start2), .din(din2), .din_valid(din_valid2),
        .din_ready(din_ready2), .sramConfig(sram2), .cbconfig(cb2), .sconfig(sb2),
        .busy(busy2), .config_valid(cv2), .error(err2), .fabric_reset(fr2)
    );

    int n_checks = 0;
    int n_err = 0;
    int c0 = 0;
    exp_t sb_q[$];
    exp_t last_good = '0;

    logic [SR-1:0]  m_sram;
    logic [CBB-1:0] m_cb;
    logic [SBB-1:0] m_sb;
    logic [W-1:0]   words[NW];
    logic [W-1:0]   csum;
    logic [W2-1:0]  words16[NW2];
    logic [W2-1:0]  csum16;
    logic [W2-1:0]  csum16_nopad;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Random config with the adder's leading byte; 16-bit stream gets nonzero padding.
    task automatic build_cfg();
        logic [NW*W-1:0]   s;
        logic [NW2*W2-1:0] s2;
        logic [NW2*W2-1:0] s2z;
        logic [PD2-1:0]    padv;
        for (int i = 0; i < SR; i++)  m_sram[i] = 1'($urandom);
        for (int i = 0; i < CBB; i++) m_cb[i]   = 1'($urandom);
        for (int i = 0; i < SBB; i++) m_sb[i]   = 1'($urandom);
        m_sram[SR-1 -: 8] = 8'h96;
        s = {m_sram, m_cb, m_sb, {PD{1'b0}}};
        csum = '0;
        for (int i = 0; i < NW; i++) begin
            words[i] = s[NW*W-1-i*W -: W];
            csum ^= words[i];
        end
        padv = PD2'(12'hA5C);
        s2  = {m_sram, m_cb, m_sb, padv};
        s2z = {m_sram, m_cb, m_sb, {PD2{1'b0}}};
        csum16 = '0;
        csum16_nopad = '0;
        for (int i = 0; i < NW2; i++) begin
            words16[i] = s2[NW2*W2-1-i*W2 -: W2];
            csum16 ^= words16[i];
            csum16_nopad ^= s2z[NW2*W2-1-i*W2 -: W2];
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        din_valid = 1'b1;
        din = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        din_valid = 1'b0;
        c0 = cyc;
    endtask

    task automatic send_words(input int first, input int count, input int gap);
        int i = first;
        int budget = count * 20 + 50;
        logic xfer;
        while (i < first + count && budget > 0) begin
            din = words[i];
            din_valid = ($urandom_range(99) >= gap);
            xfer = din_valid && din_ready;
            @(negedge clk);
            if (xfer) i++;
            budget--;
        end
        din_valid = 1'b0;
        chk("words_sent", i, first + count);
    endtask

    task automatic send_csum(input logic [W-1:0] c, input int gap);
        int budget = 50;
        logic done = 1'b0;
        logic xfer;
        while (!done && budget > 0) begin
            din = c;
            din_valid = ($urandom_range(99) >= gap);
            xfer = din_valid && din_ready;
            @(negedge clk);
            if (xfer) done = 1'b1;
            budget--;
        end
        din_valid = 1'b0;
        chk("csum_sent", done, 1'b1);
    endtask

    task automatic push_exp(input bit good);
        exp_t e;
        if (good) begin
            e = {m_sram, m_cb, m_sb, 1'b1, 1'b0};
            last_good = e;
        end else begin
            e = last_good;
            e.cv = 1'b0;
            e.err = 1'b1;
        end
        sb_q.push_back(e);
    endtask

    task automatic check_result(input string tag, input int exp_wait);
        exp_t e;
        int n = 0;
        while (!(config_valid || error) && n < 10) begin
            @(negedge clk);
            n++;
        end
        e = sb_q.pop_front();
        chk({tag, "_wait"}, n, exp_wait);
        chk({tag, "_sram"}, sram, e.sram);
        chk({tag, "_cb"}, cb, e.cb);
        chk({tag, "_sb"}, sb, e.sb);
        chk({tag, "_cv"}, config_valid, e.cv);
        chk({tag, "_err"}, error, e.err);
        chk({tag, "_freset"}, fabric_reset, !e.cv);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic load16(input logic [W2-1:0] c);
        int i = 0;
        int budget = 400;
        logic xfer;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        while (i <= NW2 && budget > 0) begin
            din2 = (i < NW2) ? words16[i] : c;
            din_valid2 = 1'b1;
            xfer = din_ready2;
            @(negedge clk);
            if (xfer) i++;
            budget--;
        end
        din_valid2 = 1'b0;
        chk("w16_sent", i, NW2 + 1);
    endtask

    task automatic check16(input string tag, input int exp_wait);
        exp_t e;
        int n = 0;
        while (!(cv2 || err2) && n < 10) begin
            @(negedge clk);
            n++;
        end
        e = sb_q.pop_front();
        chk({tag, "_wait"}, n, exp_wait);
        chk({tag, "_sram"}, sram2, e.sram);
        chk({tag, "_cb"}, cb2, e.cb);
        chk({tag, "_sb"}, sb2, e.sb);
        chk({tag, "_cv"}, cv2, e.cv);
        chk({tag, "_err"}, err2, e.err);
        chk({tag, "_freset"}, fr2, !e.cv);
        chk({tag, "_busy"}, busy2, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        start = 1'b0; din = '0; din_valid = 1'b0;
        start2 = 1'b0; din2 = '0; din_valid2 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        chk("rst_sram", sram, '0);
        chk("rst_cb", cb, '0);
        chk("rst_sb", sb, '0);
        chk("rst_ready", din_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cv", config_valid, 1'b0);
        chk("rst_err", error, 1'b0);
        chk("rst_freset", fabric_reset, 1'b1);

        // Gap-free default load, with end-to-end latency from the start edge.
        build_cfg();
        do_start();
        chk("load_ready", din_ready, 1'b1);
        chk("load_busy", busy, 1'b1);
        chk("load_freset", fabric_reset, 1'b1);
        send_words(0, NW, 0);
        push_exp(1'b1);
        send_csum(csum, 0);
        check_result("good", 1);
        chk("latency", cyc - c0, NW + 2);

        // Corrupted checksum on a new config: fabric keeps the old one.
        build_cfg();
        do_start();
        send_words(0, NW, 0);
        push_exp(1'b0);
        send_csum(csum ^ 8'h01, 0);
        check_result("badcsum", 0);

        do_start();
        send_words(0, NW, 0);
        push_exp(1'b1);
        send_csum(csum, 0);
        check_result("recover", 1);

        // Roughly half the beats idle.
        build_cfg();
        do_start();
        send_words(0, NW, 50);
        push_exp(1'b1);
        send_csum(csum, 50);
        check_result("backpressure", 1);

        // Abort after 40 words of stale data, then a full new stream.
        do_start();
        send_words(0, 40, 0);
        build_cfg();
        do_start();
        send_words(0, NW, 30);
        push_exp(1'b1);
        send_csum(csum, 0);
        check_result("abort", 1);

        // Asynchronous reset in the middle of a load.
        do_start();
        send_words(0, 60, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_sram", sram, '0);
        chk("arst_cb", cb, '0);
        chk("arst_sb", sb, '0);
        chk("arst_ready", din_ready, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_cv", config_valid, 1'b0);
        chk("arst_freset", fabric_reset, 1'b1);
        chk("arst_shadow", dut.r_shadow == '0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("arst_idle_ready", din_ready, 1'b0);
        last_good = '0;

        // 16-bit stream with nonzero padding bits.
        build_cfg();
        push_exp(1'b1);
        load16(csum16);
        check16("w16_good", 1);
        push_exp(1'b0);
        load16(csum16_nopad);
        check16("w16_padcsum", 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
